// File: rtl/sync_down_counter_mod.sv
// Synchronous, loadable modulo-MODULUS down counter with cascade borrow and a sticky wrap flag.
// Optional macro SYNC_DOWN_COUNTER_ONE_SHOT_EN makes it saturate at zero and flag the 1 -> 0 terminal event.
module sync_down_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             zero,
    output logic             borrow,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_next;
    logic             wrap_event;
    logic             wrapped_next;
    logic             at_zero;
    logic             din_over;

    assign at_zero  = (q == '0);
    // Compare one bit wider so MODULUS = 2**WIDTH never clamps.
    assign din_over = ({1'b0, din} > MAX_EXT);

    always_comb begin
        q_next     = q;
        wrap_event = 1'b0;
        if (load) begin
            q_next = din_over ? MAX_Q : din;
        end else if (en && !at_zero) begin
            q_next = q - ONE;
`ifdef SYNC_DOWN_COUNTER_ONE_SHOT_EN
            wrap_event = (q == ONE);
`endif
        end else if (en) begin
`ifdef SYNC_DOWN_COUNTER_ONE_SHOT_EN
            q_next = q;
`else
            q_next     = MAX_Q;
            wrap_event = 1'b1;
`endif
        end
    end

    // A wrap on the same edge as clr_flag keeps the flag set.
    always_comb begin
        wrapped_next = wrapped;
        if (wrap_event) begin
            wrapped_next = 1'b1;
        end else if (clr_flag) begin
            wrapped_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            wrapped <= 1'b0;
        end else begin
            q       <= q_next;
            wrapped <= wrapped_next;
        end
    end

    assign qb     = ~q;
    assign zero   = at_zero;
    assign borrow = en & ~load & at_zero;

endmodule
